// File: rtl/multicycle_control_pkg.sv
// -----------------------------------------------------------------------------
// control_pkg
// Shared definitions for the multicycle control unit: the opcodes it
// recognises, ALU operation and ALU B-source encodings, the controller state
// enumeration, and a helper that maps a decoded opcode to its first
// execution state.
// -----------------------------------------------------------------------------
package control_pkg;

   // Opcodes (instruction[6:0])
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_LD  = 7'b0000011;
   localparam logic [6:0] OP_SD  = 7'b0100011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;

   // ALU operation encodings
   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;

   // ALU B-operand source encodings
   localparam logic [1:0] SRCB_REG  = 2'b00;
   localparam logic [1:0] SRCB_FOUR = 2'b01;
   localparam logic [1:0] SRCB_IMM  = 2'b10;

   typedef enum logic [3:0] {
      S_IDLE     = 4'd0,
      S_FETCH    = 4'd1,
      S_DECODE   = 4'd2,
      S_MEM_ADDR = 4'd3,
      S_MEM_RD   = 4'd4,
      S_MEM_WB   = 4'd5,
      S_MEM_WR   = 4'd6,
      S_EXEC     = 4'd7,
      S_ALU_WB   = 4'd8,
      S_BRANCH   = 4'd9,
      S_TRAP     = 4'd10
   } state_t;

   // State that follows DECODE for a given opcode; anything unsupported traps.
   function automatic state_t decode_next(input logic [6:0] op);
      case (op)
         OP_R:         return S_EXEC;
         OP_LD, OP_SD: return S_MEM_ADDR;
         OP_BEQ:       return S_BRANCH;
         default:      return S_TRAP;
      endcase
   endfunction

endpackage

// File: rtl/multicycle_control_perf_counter.sv
// -----------------------------------------------------------------------------
// perf_counter
// 32-bit free-running event counter; counts one per clock while i_en is high
// and wraps from 0xFFFFFFFF to 0.
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset, clears the count
//   i_en     count enable
//   o_count  current count
// -----------------------------------------------------------------------------
module perf_counter (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_en,
   output logic [31:0] o_count
);

   logic [31:0] r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (i_en) begin
         r_count <= r_count + 32'd1;
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
// Moore-style control FSM for a multicycle datapath supporting R-type, load,
// store and branch-equal instructions. Unsupported opcodes park the FSM in
// TRAP with a sticky illegal flag until reset.
//
// Optional feature: define MULTICYCLE_CONTROL_PERF_EN to count retired
// instructions on 'retired'; otherwise 'retired' is tied to 0.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   opcode[6:0]         instruction[6:0] from the external IR
//   zero                ALU zero flag (combined with pc_write_cond outside)
//   mem_ready           completes the current memory access
//   pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write,
//   mem_to_reg, reg_write, alu_src_a, alu_src_b[1:0], alu_op  datapath control
//   illegal             sticky unsupported-opcode flag
//   state_dbg[3:0]      current state encoding
//   retired[31:0]       retired-instruction count
// -----------------------------------------------------------------------------
module multicycle_control
   import control_pkg::*;
#(
   parameter int ALU_OP_W = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [6:0]          opcode,
   input  logic                zero,
   input  logic                mem_ready,
   output logic                pc_write,
   output logic                pc_write_cond,
   output logic                ir_write,
   output logic                i_or_d,
   output logic                mem_read,
   output logic                mem_write,
   output logic                mem_to_reg,
   output logic                reg_write,
   output logic                alu_src_a,
   output logic [1:0]          alu_src_b,
   output logic [ALU_OP_W-1:0] alu_op,
   output logic                illegal,
   output logic [3:0]          state_dbg,
   output logic [31:0]         retired
);

   state_t     r_state;
   state_t     w_next;
   logic [6:0] r_op_q;
   logic       r_run;
   logic       r_illegal;

   // zero is gated with pc_write_cond in the datapath, never inside this block.
   logic       w_unused_zero;
   assign w_unused_zero = zero;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_op_q    <= '0;
         r_run     <= 1'b0;
         r_illegal <= 1'b0;
      end else begin
         r_state <= w_next;
         r_run   <= 1'b1;
         if (r_state == S_DECODE) begin
            r_op_q <= opcode;
         end
         if (w_next == S_TRAP) begin
            r_illegal <= 1'b1;
         end
      end
   end

   always_comb begin
      w_next        = r_state;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      ir_write      = 1'b0;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      mem_to_reg    = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = SRCB_REG;
      alu_op        = ALU_OP_W'(ALU_ADD);

      case (r_state)
         // The first edge after reset release only arms r_run, so the first
         // FETCH lands on the second edge and reset release never races it.
         S_IDLE: begin
            if (r_run) begin
               w_next = S_FETCH;
            end
         end
         // Fetch also computes PC+4; IR and PC update when memory responds.
         S_FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = SRCB_FOUR;
            ir_write  = mem_ready;
            pc_write  = mem_ready;
            if (mem_ready) begin
               w_next = S_DECODE;
            end
         end
         // Decode precomputes the branch target PC + imm.
         S_DECODE: begin
            alu_src_b = SRCB_IMM;
            w_next    = decode_next(opcode);
         end
         S_MEM_ADDR: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
            w_next    = (r_op_q == OP_LD) ? S_MEM_RD : S_MEM_WR;
         end
         S_MEM_RD: begin
            mem_read = 1'b1;
            i_or_d   = 1'b1;
            if (mem_ready) begin
               w_next = S_MEM_WB;
            end
         end
         S_MEM_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            w_next     = S_FETCH;
         end
         S_MEM_WR: begin
            mem_write = 1'b1;
            i_or_d    = 1'b1;
            if (mem_ready) begin
               w_next = S_FETCH;
            end
         end
         S_EXEC: begin
            alu_src_a = 1'b1;
            alu_op    = ALU_OP_W'(ALU_FUNCT);
            w_next    = S_ALU_WB;
         end
         S_ALU_WB: begin
            reg_write = 1'b1;
            w_next    = S_FETCH;
         end
         S_BRANCH: begin
            alu_src_a     = 1'b1;
            alu_op        = ALU_OP_W'(ALU_SUB);
            pc_write_cond = 1'b1;
            w_next        = S_FETCH;
         end
         S_TRAP: begin
            w_next = S_TRAP;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   assign illegal   = r_illegal;
   assign state_dbg = r_state;

`ifdef MULTICYCLE_CONTROL_PERF_EN
   // An instruction retires on the edge that leaves its final state.
   logic w_retire;
   assign w_retire = (r_state == S_MEM_WB) ||
                     ((r_state == S_MEM_WR) && mem_ready) ||
                     (r_state == S_ALU_WB) ||
                     (r_state == S_BRANCH);

   perf_counter u_perf_counter (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_en    (w_retire),
      .o_count (retired)
   );
`else
   assign retired = 32'd0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
`timescale 1ns/1ps
module tb_multicycle_control;
   import control_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [6:0]  opcode = '0;
   logic        zero = 1'b0;
   logic        mem_ready = 1'b0;
   logic        pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write;
   logic        mem_to_reg, reg_write, alu_src_a, illegal;
   logic [1:0]  alu_src_b, alu_op;
   logic [3:0]  state_dbg;
   logic [31:0] retired;

   multicycle_control #(.ALU_OP_W(2)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
      .pc_write(pc_write), .pc_write_cond(pc_write_cond), .ir_write(ir_write),
      .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
      .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .alu_op(alu_op), .illegal(illegal),
      .state_dbg(state_dbg), .retired(retired)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic pcw, pcwc, irw, iord, mrd, mwr, m2r, rw, asa;
      logic [1:0] asb, aop;
      logic ill;
   } ctl_t;

   // One expected clock cycle: inputs to drive and outputs to expect.
   typedef struct {
      logic [6:0]  op;
      logic        mr;
      logic        z;
      state_t      st;
      ctl_t        ctl;
      logic [31:0] ret;
   } cyc_t;

   // Directed instruction vectors with their FETCH-to-FETCH latency.
   typedef struct {
      logic [6:0] op;
      int         fw;
      int         mw;
      logic       z;
      int         lat;
   } vec_t;

   cyc_t        q[$];
   vec_t        tbl[8];
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] model_ret = '0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic rb();
      return 1'($urandom);
   endfunction

   function automatic logic [6:0] ro();
      return 7'($urandom);
   endfunction

   // Output table straight from the state descriptions.
   function automatic ctl_t spec_ctl(input state_t s, input logic mr);
      ctl_t c;
      c = '0;
      case (s)
         S_FETCH:    begin c.mrd = 1; c.asb = 2'b01; c.irw = mr; c.pcw = mr; end
         S_DECODE:   begin c.asb = 2'b10; end
         S_MEM_ADDR: begin c.asa = 1; c.asb = 2'b10; end
         S_MEM_RD:   begin c.mrd = 1; c.iord = 1; end
         S_MEM_WB:   begin c.rw = 1; c.m2r = 1; end
         S_MEM_WR:   begin c.mwr = 1; c.iord = 1; end
         S_EXEC:     begin c.asa = 1; c.aop = 2'b10; end
         S_ALU_WB:   begin c.rw = 1; end
         S_BRANCH:   begin c.asa = 1; c.aop = 2'b01; c.pcwc = 1; end
         S_TRAP:     begin c.ill = 1; end
         default:    ;
      endcase
      return c;
   endfunction

   function automatic ctl_t dut_ctl();
      ctl_t c;
      c.pcw = pc_write; c.pcwc = pc_write_cond; c.irw = ir_write; c.iord = i_or_d;
      c.mrd = mem_read; c.mwr = mem_write; c.m2r = mem_to_reg; c.rw = reg_write;
      c.asa = alu_src_a; c.asb = alu_src_b; c.aop = alu_op; c.ill = illegal;
      return c;
   endfunction

   task automatic push(input state_t s, input logic mr, input logic [6:0] op, input logic z);
      cyc_t e;
      e.st = s; e.mr = mr; e.op = op; e.z = z; e.ctl = spec_ctl(s, mr);
`ifdef MULTICYCLE_CONTROL_PERF_EN
      e.ret = model_ret;
`else
      e.ret = 32'd0;
`endif
      q.push_back(e);
   endtask

   // Instruction-level model: expands one instruction into its cycle list.
   // Opcode is only meaningful in DECODE; everywhere else it is random noise,
   // as is mem_ready outside memory waits and zero outside BRANCH.
   task automatic expand(input logic [6:0] op, input int fw, input int mw, input logic z);
      for (int i = 0; i < fw; i++) push(S_FETCH, 1'b0, ro(), rb());
      push(S_FETCH, 1'b1, ro(), rb());
      push(S_DECODE, rb(), op, rb());
      if (op == OP_R) begin
         push(S_EXEC, rb(), ro(), rb());
         push(S_ALU_WB, rb(), ro(), rb());
         model_ret++;
      end else if (op == OP_LD) begin
         push(S_MEM_ADDR, rb(), ro(), rb());
         for (int i = 0; i < mw; i++) push(S_MEM_RD, 1'b0, ro(), rb());
         push(S_MEM_RD, 1'b1, ro(), rb());
         push(S_MEM_WB, rb(), ro(), rb());
         model_ret++;
      end else if (op == OP_SD) begin
         push(S_MEM_ADDR, rb(), ro(), rb());
         for (int i = 0; i < mw; i++) push(S_MEM_WR, 1'b0, ro(), rb());
         push(S_MEM_WR, 1'b1, ro(), rb());
         model_ret++;
      end else if (op == OP_BEQ) begin
         push(S_BRANCH, rb(), ro(), z);
         model_ret++;
      end else begin
         for (int i = 0; i < 100; i++) push(S_TRAP, rb(), ro(), rb());
      end
   endtask

   // Drive up to n queued cycles; count cycles the DUT spent executing.
   task automatic run_queue(input int n, output int active);
      cyc_t e;
      int   k;
      k = 0;
      active = 0;
      while (q.size() > 0 && k < n) begin
         e = q.pop_front();
         k++;
         @(posedge clk);
         #1;
         opcode = e.op; mem_ready = e.mr; zero = e.z;
         @(negedge clk);
         if (state_dbg != 4'(S_IDLE) && state_dbg != 4'(S_TRAP)) active++;
         chk($sformatf("state(%s)", e.st.name()), 32'(state_dbg), 32'(e.st));
         chk($sformatf("ctl(%s)", e.st.name()), 32'(dut_ctl()), 32'(e.ctl));
         chk($sformatf("retired(%s)", e.st.name()), retired, e.ret);
         if (e.st == S_BRANCH)
            chk("branch_pc_enable", 32'(pc_write_cond & zero), 32'(e.z));
      end
   endtask

   // Asynchronous reset between clock edges; released just after a rising edge.
   task automatic do_reset();
      #2;
      rst_n = 1'b0;
      #1;
      chk("reset_state", 32'(state_dbg), 32'(S_IDLE));
      chk("reset_ctl", 32'(dut_ctl()), 32'd0);
      chk("reset_retired", retired, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_ret = '0;
   endtask

   initial begin
      int   lat;
      int   sel;
      logic [6:0] rop;

      tbl[0] = '{OP_R,   0, 0, 1'b0, 4};
      tbl[1] = '{OP_LD,  0, 3, 1'b0, 8};
      tbl[2] = '{OP_SD,  0, 0, 1'b0, 4};
      tbl[3] = '{OP_BEQ, 0, 0, 1'b1, 3};
      tbl[4] = '{OP_BEQ, 0, 0, 1'b0, 3};
      tbl[5] = '{OP_R,   2, 0, 1'b0, 6};
      tbl[6] = '{OP_SD,  1, 2, 1'b0, 7};
      tbl[7] = '{OP_LD,  0, 0, 1'b0, 5};

      do_reset();
      // Edge 1 after release stays in IDLE; edge 2 enters FETCH.
      push(S_IDLE, rb(), ro(), rb());
      run_queue(1, lat);

      for (int i = 0; i < 8; i++) begin
         expand(tbl[i].op, tbl[i].fw, tbl[i].mw, tbl[i].z);
         run_queue(1000, lat);
         chk($sformatf("latency[%0d]", i), lat, tbl[i].lat);
         if (i == 3) begin
`ifdef MULTICYCLE_CONTROL_PERF_EN
            chk("retired_after_r_ld_sd_beq", retired, 32'd4);
`else
            chk("retired_after_r_ld_sd_beq", retired, 32'd0);
`endif
         end
      end

      // Random legal instruction stream.
      for (int i = 0; i < 60; i++) begin
         sel = int'($urandom_range(0, 3));
         case (sel)
            0:       rop = OP_R;
            1:       rop = OP_LD;
            2:       rop = OP_SD;
            default: rop = OP_BEQ;
         endcase
         expand(rop, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), rb());
         run_queue(1000, lat);
      end

      // Reset while a store waits on mem_ready: write must drop immediately.
      do_reset();
      push(S_IDLE, rb(), ro(), rb());
      expand(OP_SD, 0, 5, 1'b0);
      run_queue(6, lat);
      q.delete();
      chk("memwr_wait_mem_write", 32'(mem_write), 32'd1);
      do_reset();
      push(S_IDLE, rb(), ro(), rb());
      expand(OP_R, 0, 0, 1'b0);
      run_queue(1000, lat);

      // Illegal opcode: TRAP for 100 cycles, then a reset pulse recovers.
      expand(7'b1111111, 0, 0, 1'b0);
      run_queue(1000, lat);
      chk("trap_illegal_sticky", 32'(illegal), 32'd1);
      do_reset();
      chk("trap_cleared_illegal", 32'(illegal), 32'd0);
      push(S_IDLE, rb(), ro(), rb());
      expand(OP_BEQ, 0, 0, 1'b1);
      run_queue(1000, lat);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter ALU_OP_W, default 2: alu_op width.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 opcode  input  7  instruction[6:0] from external IR.
REQ-005 zero  input  1  ALU zero flag.
REQ-006 mem_ready  input  1  memory done; completes current FETCH/MEM_READ/MEM_WRITE access.
REQ-007 Control outputs, 1 bit each unless stated:
- pc_write, pc_write_cond, ir_write
- i_or_d: 0 = PC address, 1 = ALUOut address
- mem_read, mem_write, mem_to_reg, reg_write
- alu_src_a: 0 = PC, 1 = reg A
- alu_src_b [1:0]: 00 = reg B, 01 = const 4, 10 = immediate
- alu_op [ALU_OP_W-1:0]
REQ-008 illegal  output  1  sticky unsupported-opcode flag.
REQ-009 state_dbg  output  4  current state encoding.
REQ-010 retired  output  32  retired-instruction count (see Configuration).

Function
REQ-011 Moore FSM; outputs decoded from registered state only.
REQ-012 Exception to REQ-011: pc_write_cond AND zero forms PC enable externally; the block does not register zero.
REQ-013 States: IDLE, FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, EXEC, ALU_WB, BRANCH, TRAP.
REQ-014 IDLE: all outputs 0; next state always FETCH.
REQ-015 FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00; ir_write=pc_write=mem_ready; hold until mem_ready=1, then DECODE.
REQ-016 DECODE: latch opcode into op_q; alu_src_a=0, alu_src_b=10, alu_op=00 (branch target).
REQ-017 DECODE transitions: 0110011 -> EXEC; 0000011 or 0100011 -> MEM_ADDR; 1100011 -> BRANCH; other -> TRAP.
REQ-018 MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00; op_q load -> MEM_RD, store -> MEM_WR.
REQ-019 MEM_RD: mem_read=1, i_or_d=1; hold until mem_ready=1, then MEM_WB.
REQ-020 MEM_WB: reg_write=1, mem_to_reg=1; then FETCH.
REQ-021 MEM_WR: mem_write=1, i_or_d=1; hold until mem_ready=1, then FETCH.
REQ-022 EXEC: alu_src_a=1, alu_src_b=00, alu_op=10; then ALU_WB.
REQ-023 ALU_WB: reg_write=1, mem_to_reg=0; then FETCH.
REQ-024 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1; then FETCH.
REQ-025 Latency with mem_ready tied 1: R=4, ld=5, sd=4, beq=3 cycles FETCH-to-FETCH; each mem_ready=0 cycle adds one.
REQ-026 TRAP: all control outputs 0, illegal=1; no exit except reset.
REQ-027 mem_read and mem_write are never both 1 in any state.
REQ-028 opcode changes outside DECODE have no effect; control uses op_q only.

Reset
REQ-029 rst_n low: state=IDLE, op_q=0, illegal=0, retired=0, all control outputs 0, immediately (async).
REQ-030 Reset mid-access (including while waiting on mem_ready) abandons the instruction; no write asserted after assertion.
REQ-031 First FETCH occurs on the second rising edge after rst_n deasserts.

Configuration
REQ-032 Macro MULTICYCLE_CONTROL_PERF_EN.
- Defined: retired increments by 1 on each exit from MEM_WB, MEM_WR (on mem_ready), ALU_WB and BRANCH; wraps 0xFFFFFFFF -> 0.
- Undefined: retired is constant 0; no counter logic.

Structure
REQ-033 Shared package control_pkg holds:
- opcode constants: R=0110011, LD=0000011, SD=0100011, BEQ=1100011
- ALU op encodings: 00 add, 01 sub/compare, 10 funct-decoded
- alu_src_b encodings and the state enumeration
REQ-034 One sub-module perf_counter (32-bit, enable input), instantiated only under MULTICYCLE_CONTROL_PERF_EN.

Verification
REQ-035 Reset release, mem_ready=1, opcode=0110011: states IDLE, FETCH, DECODE, EXEC, ALU_WB, FETCH; reg_write=1 only in ALU_WB; alu_op=10 in EXEC.
REQ-036 opcode=0000011, mem_ready low 3 cycles in MEM_RD: MEM_RD held 4 cycles, mem_read=1, i_or_d=1 throughout; MEM_WB reg_write=1, mem_to_reg=1.
REQ-037 opcode=1100011 with zero=1 then zero=0: BRANCH lasts 1 cycle, pc_write_cond=1, alu_op=01; PC enable follows zero.
REQ-038 opcode=1111111: TRAP, illegal=1, outputs 0 for 100 cycles; rst_n pulse clears illegal, returns to IDLE.
REQ-039 rst_n asserted during MEM_WR wait: mem_write drops to 0 asynchronously, state_dbg=IDLE.
REQ-040 MULTICYCLE_CONTROL_PERF_EN defined, sequence R, ld, sd, beq: retired=4; undefined: retired=0.
